// File: rtl/multi_change_detect.sv
// multi_change_detect: debounces NCH sampled code channels, commits stable
// values and reports masked commits one at a time over a valid/ack handshake.
module multi_change_detect #(
    parameter int                NCH           = 2,
    parameter int                W             = 3,
    parameter int                STABLE_CYCLES = 3,
    parameter logic [(2**W)-1:0] TRIG_MASK     = 8'b0000_1110,
    parameter int                CW            = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_set_done,
    input  logic [NCH*W-1:0] ch_value,
    input  logic             ack,
    output logic             detect,
    output logic             evt_valid,
    output logic [CW-1:0]    evt_ch,
    output logic [W-1:0]     evt_code,
    output logic [NCH*W-1:0] s_value,
    output logic [NCH-1:0]   overflow
);

    localparam int              CNTW    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(STABLE_CYCLES);

    typedef enum logic {
        IDLE,
        REPORT
    } state_t;

    state_t state_q, state_d;

    logic [NCH-1:0][W-1:0]    ch_val;
    logic [NCH-1:0][W-1:0]    committed_q, committed_d;
    logic [NCH-1:0][W-1:0]    cand_q, cand_d;
    logic [NCH-1:0][CNTW-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]           pending_q, pending_d;
    logic [NCH-1:0]           overflow_q, overflow_d;
    logic [NCH-1:0]           commit_set;
    logic [NCH-1:0]           ack_clr;

    logic                     any_pend;
    logic [CW-1:0]            low_idx;

    logic [CW-1:0]            evt_ch_q, evt_ch_d;
    logic [W-1:0]             evt_code_q, evt_code_d;
    logic                     detect_q, detect_d;

    assign ch_val = ch_value;

    // Per-channel debounce: track candidate, count qualified repeats, commit at threshold.
    always_comb begin
        committed_d = committed_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        commit_set  = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (data_set_done) begin
                if (ch_val[c] == committed_q[c]) begin
                    cnt_d[c] = '0;
                end else begin
                    if (ch_val[c] == cand_q[c]) begin
                        cnt_d[c] = (cnt_q[c] >= CNT_MAX) ? CNT_MAX : cnt_q[c] + CNTW'(1);
                    end else begin
                        cand_d[c] = ch_val[c];
                        cnt_d[c]  = CNTW'(1);
                    end
                    // The post-update count decides the commit on this same edge.
                    if (cnt_d[c] == CNT_MAX) begin
                        committed_d[c] = ch_val[c];
                        cnt_d[c]       = '0;
                        commit_set[c]  = TRIG_MASK[ch_val[c]];
                    end
                end
            end
        end
    end

    // Pending bookkeeping: ack clears the reported channel, a new commit wins over the clear.
    always_comb begin
        ack_clr = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            ack_clr[c] = (state_q == REPORT) && ack && (evt_ch_q == CW'(c));
        end
        pending_d  = (pending_q & ~ack_clr) | commit_set;
        overflow_d = overflow_q | (commit_set & pending_q & ~ack_clr);
    end

    // Fixed-priority pick of the lowest pending channel.
    always_comb begin
        any_pend = 1'b0;
        low_idx  = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (pending_q[c] && !any_pend) begin
                any_pend = 1'b1;
                low_idx  = CW'(c);
            end
        end
    end

    // Report FSM next-state and latched event fields.
    always_comb begin
        state_d    = state_q;
        evt_ch_d   = evt_ch_q;
        evt_code_d = evt_code_q;
        detect_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_pend) begin
                    state_d    = REPORT;
                    evt_ch_d   = low_idx;
                    evt_code_d = committed_q[low_idx];
                    detect_d   = 1'b1;
                end
            end
            REPORT: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            committed_q <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            pending_q   <= '0;
            overflow_q  <= '0;
        end else begin
            committed_q <= committed_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
        end
    end

    // FSM state register and registered event outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            evt_ch_q   <= '0;
            evt_code_q <= '0;
            detect_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            evt_ch_q   <= evt_ch_d;
            evt_code_q <= evt_code_d;
            detect_q   <= detect_d;
        end
    end

    assign evt_valid = (state_q == REPORT);
    assign detect    = detect_q;
    assign evt_ch    = evt_ch_q;
    assign evt_code  = evt_code_q;
    assign s_value   = committed_q;
    assign overflow  = overflow_q;

endmodule
